// File: rtl/hb2_pkg.sv
// Hummingbird-2 WD16 building blocks shared by the keyed-permutation pipeline.
// The 16-bit word is split MSB-first into nibbles: S1 maps bits [15:12],
// S2 maps [11:8], S3 maps [7:4] and S4 maps [3:0].
// The inverse tables and inverse layers are used only when WD16_DECRYPT_EN is defined.
package hb2_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] S1 [16] = '{4'h7, 4'hC, 4'hE, 4'h9, 4'h2, 4'h1, 4'h5, 4'hF,
                                       4'hB, 4'h6, 4'hD, 4'h0, 4'h4, 4'h8, 4'hA, 4'h3};
    localparam logic [3:0] S2 [16] = '{4'h4, 4'hA, 4'h1, 4'h6, 4'h8, 4'hF, 4'h7, 4'hC,
                                       4'h3, 4'h0, 4'hE, 4'hD, 4'h5, 4'h9, 4'hB, 4'h2};
    localparam logic [3:0] S3 [16] = '{4'h2, 4'hF, 4'hC, 4'h1, 4'h5, 4'h6, 4'hA, 4'hD,
                                       4'hE, 4'h8, 4'h3, 4'h4, 4'h0, 4'hB, 4'h9, 4'h7};
    localparam logic [3:0] S4 [16] = '{4'hF, 4'h4, 4'h5, 4'h8, 4'h9, 4'h7, 4'h2, 4'h1,
                                       4'hA, 4'h3, 4'h0, 4'hE, 4'h6, 4'hC, 4'hD, 4'hB};

    localparam logic [3:0] S1_INV [16] = '{4'hB, 4'h5, 4'h4, 4'hF, 4'hC, 4'h6, 4'h9, 4'h0,
                                           4'hD, 4'h3, 4'hE, 4'h8, 4'h1, 4'hA, 4'h2, 4'h7};
    localparam logic [3:0] S2_INV [16] = '{4'h9, 4'h2, 4'hF, 4'h8, 4'h0, 4'hC, 4'h3, 4'h6,
                                           4'h4, 4'hD, 4'h1, 4'hE, 4'h7, 4'hB, 4'hA, 4'h5};
    localparam logic [3:0] S3_INV [16] = '{4'hC, 4'h3, 4'h0, 4'hA, 4'hB, 4'h4, 4'h5, 4'hF,
                                           4'h9, 4'hE, 4'h6, 4'hD, 4'h2, 4'h7, 4'h8, 4'h1};
    localparam logic [3:0] S4_INV [16] = '{4'hA, 4'h7, 4'h6, 4'h9, 4'h1, 4'h2, 4'hC, 4'h5,
                                           4'h3, 4'h4, 4'h8, 4'hF, 4'hD, 4'hE, 4'hB, 4'h0};

    function automatic logic [WORD_W-1:0] rotl16(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sboxLayer(input logic [WORD_W-1:0] x);
        return {S1[x[15:12]], S2[x[11:8]], S3[x[7:4]], S4[x[3:0]]};
    endfunction

    function automatic logic [WORD_W-1:0] invSboxLayer(input logic [WORD_W-1:0] x);
        return {S1_INV[x[15:12]], S2_INV[x[11:8]], S3_INV[x[7:4]], S4_INV[x[3:0]]};
    endfunction

    function automatic logic [WORD_W-1:0] linLayer(input logic [WORD_W-1:0] x);
        return x ^ rotl16(x, 6) ^ rotl16(x, 10);
    endfunction

    // Inverse of 1 + x^6 + x^10 in GF(2)[x]/(x^16 + 1) is 1 + x^2 + x^4 + x^12 + x^14.
    function automatic logic [WORD_W-1:0] invLinLayer(input logic [WORD_W-1:0] x);
        return x ^ rotl16(x, 2) ^ rotl16(x, 4) ^ rotl16(x, 12) ^ rotl16(x, 14);
    endfunction

    function automatic logic [WORD_W-1:0] wdF(input logic [WORD_W-1:0] x);
        return linLayer(sboxLayer(x));
    endfunction

    function automatic logic [WORD_W-1:0] wdFInv(input logic [WORD_W-1:0] x);
        return invSboxLayer(invLinLayer(x));
    endfunction

endpackage

// File: rtl/wd16_pipe_if.sv
// Word/keys/tag bundle for the WD16 pipeline: valid/ready on the input
// and output sides plus the busy indicator.
interface wd16_pipe_if #(
    parameter int NUM_ROUNDS = 4,
    parameter int TAG_W      = 4
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic [hb2_pkg::WORD_W-1:0]               in_data;
    logic [hb2_pkg::WORD_W*NUM_ROUNDS-1:0]    in_keys;
    logic [TAG_W-1:0]                         in_tag;
    logic                                     in_dec;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [hb2_pkg::WORD_W-1:0]               out_data;
    logic [TAG_W-1:0]                         out_tag;
    logic                                     busy;

    modport slave (
        input  in_valid, in_data, in_keys, in_tag, in_dec, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );

    modport master (
        output in_valid, in_data, in_keys, in_tag, in_dec, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/wd16_pipe_round.sv
// One combinational WD16 round. Encrypt computes f(s ^ k); the inverse
// direction finv(s) ^ k exists only when WD16_DECRYPT_EN is defined.
module wd16_round
    import hb2_pkg::*;
(
    input  logic [WORD_W-1:0] s_i,
    input  logic [WORD_W-1:0] k_i,
    input  logic              dec_i,
    output logic [WORD_W-1:0] out_o
);

`ifdef WD16_DECRYPT_EN
    // Select forward or inverse round per word.
    always_comb begin
        out_o = wdF(s_i ^ k_i);
        if (dec_i) out_o = wdFInv(s_i) ^ k_i;
    end
`else
    logic unusedDec;
    assign unusedDec = dec_i;

    // Forward round only.
    always_comb begin
        out_o = wdF(s_i ^ k_i);
    end
`endif

endmodule

// File: rtl/wd16_pipe.sv
// Flow-controlled WD16 keyed permutation, one registered stage per round.
// Stage j registers the word entering round j together with the keys still
// needed (held in consumption order, so stage j keeps NUM_ROUNDS-j keys);
// the round logic sits behind each register and the last round drives out_data.
// Optional macro: WD16_DECRYPT_EN adds a per-word inverse (decrypt) mode.
module wd16_pipe
    import hb2_pkg::*;
#(
    parameter int NUM_ROUNDS = 4,
    parameter int TAG_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    wd16_pipe_if.slave  bus
);

    logic [NUM_ROUNDS-1:0] advance;
    logic [NUM_ROUNDS-1:0] stageValid;
    logic [WORD_W-1:0]     orderedKeys [NUM_ROUNDS];

    // A stage may load when it or any later stage has a hole, or the sink takes the output.
    always_comb begin
        for (int j = 0; j < NUM_ROUNDS; j++) begin
            advance[j] = bus.out_ready;
            for (int m = j; m < NUM_ROUNDS; m++) begin
                if (!stageValid[m]) advance[j] = 1'b1;
            end
        end
    end

    // Reorder incoming keys so entry i is the key consumed by round i in this word's direction.
    always_comb begin
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            orderedKeys[i] = bus.in_keys[WORD_W*i +: WORD_W];
`ifdef WD16_DECRYPT_EN
            if (bus.in_dec) orderedKeys[i] = bus.in_keys[WORD_W*(NUM_ROUNDS-1-i) +: WORD_W];
`endif
        end
    end

`ifndef WD16_DECRYPT_EN
    logic unusedDec;
    assign unusedDec = bus.in_dec;
`endif

    for (genvar j = 0; j < NUM_ROUNDS; j++) begin : g_stage
        logic              validQ;
        logic [WORD_W-1:0] dataQ;
        logic [TAG_W-1:0]  tagQ;
        logic [WORD_W-1:0] keyQ    [NUM_ROUNDS-j];
        logic              srcValid;
        logic [WORD_W-1:0] srcData;
        logic [TAG_W-1:0]  srcTag;
        logic [WORD_W-1:0] srcKeys [NUM_ROUNDS-j];
        logic              stageDec;
        logic [WORD_W-1:0] roundOut;

        if (j == 0) begin : g_src
            assign srcValid = bus.in_valid;
            assign srcData  = bus.in_data;
            assign srcTag   = bus.in_tag;
            for (genvar m = 0; m < NUM_ROUNDS; m++) begin : g_key
                assign srcKeys[m] = orderedKeys[m];
            end
        end else begin : g_src
            assign srcValid = g_stage[j-1].validQ;
            assign srcData  = g_stage[j-1].roundOut;
            assign srcTag   = g_stage[j-1].tagQ;
            for (genvar m = 0; m < NUM_ROUNDS - j; m++) begin : g_key
                assign srcKeys[m] = g_stage[j-1].keyQ[m+1];
            end
        end

        // Stage register: move the upstream word in whenever this stage advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                validQ <= 1'b0;
                dataQ  <= '0;
                tagQ   <= '0;
                for (int m = 0; m < NUM_ROUNDS - j; m++) keyQ[m] <= '0;
            end else if (advance[j]) begin
                validQ <= srcValid;
                if (srcValid) begin
                    dataQ <= srcData;
                    tagQ  <= srcTag;
                    for (int m = 0; m < NUM_ROUNDS - j; m++) keyQ[m] <= srcKeys[m];
                end
            end
        end

`ifdef WD16_DECRYPT_EN
        logic decQ;
        logic srcDec;

        if (j == 0) begin : g_dsrc
            assign srcDec = bus.in_dec;
        end else begin : g_dsrc
            assign srcDec = g_stage[j-1].decQ;
        end

        // Direction bit travels with its word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                decQ <= 1'b0;
            end else if (advance[j] && srcValid) begin
                decQ <= srcDec;
            end
        end

        assign stageDec = decQ;
`else
        assign stageDec = 1'b0;
`endif

        wd16_round uRound (
            .s_i   (dataQ),
            .k_i   (keyQ[0]),
            .dec_i (stageDec),
            .out_o (roundOut)
        );

        assign stageValid[j] = validQ;
    end

    assign bus.in_ready  = advance[0];
    assign bus.out_valid = g_stage[NUM_ROUNDS-1].validQ;
    assign bus.out_data  = g_stage[NUM_ROUNDS-1].roundOut;
    assign bus.out_tag   = g_stage[NUM_ROUNDS-1].tagQ;
    assign bus.busy      = |stageValid;

endmodule
